// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receive path: FSM states, ASCII codes,
// symbol encoding, gap thresholds in units and a saturating run-counter increment.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SPACE,
        WORD_WAIT,
        STUCK
    } state_t;

    localparam int CNT_W = 11;

    localparam logic [9:0] ASCII_SPACE = 10'h020;
    localparam logic [9:0] ASCII_QMARK = 10'h03F;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int CHAR_GAP_UNITS = 2;
    localparam int WORD_GAP_UNITS = 5;
    localparam int STUCK_UNITS    = 5;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse pattern table: symbol count plus pattern (MSB oldest,
// dash=1) to uppercase ASCII letters A-Z and digits 0-9.
module morse_lut (
    input  logic [2:0] len_i,
    input  logic [4:0] pat_i,
    output logic       valid_o,
    output logic [9:0] ascii_o
);

    always_comb begin
        valid_o = 1'b1;
        ascii_o = 10'h000;
        case ({len_i, pat_i})
            {3'd1, 5'b00000}: ascii_o = 10'h045; // E
            {3'd1, 5'b00001}: ascii_o = 10'h054; // T
            {3'd2, 5'b00001}: ascii_o = 10'h041; // A
            {3'd2, 5'b00000}: ascii_o = 10'h049; // I
            {3'd2, 5'b00011}: ascii_o = 10'h04D; // M
            {3'd2, 5'b00010}: ascii_o = 10'h04E; // N
            {3'd3, 5'b00100}: ascii_o = 10'h044; // D
            {3'd3, 5'b00110}: ascii_o = 10'h047; // G
            {3'd3, 5'b00101}: ascii_o = 10'h04B; // K
            {3'd3, 5'b00111}: ascii_o = 10'h04F; // O
            {3'd3, 5'b00010}: ascii_o = 10'h052; // R
            {3'd3, 5'b00000}: ascii_o = 10'h053; // S
            {3'd3, 5'b00001}: ascii_o = 10'h055; // U
            {3'd3, 5'b00011}: ascii_o = 10'h057; // W
            {3'd4, 5'b01000}: ascii_o = 10'h042; // B
            {3'd4, 5'b01010}: ascii_o = 10'h043; // C
            {3'd4, 5'b00010}: ascii_o = 10'h046; // F
            {3'd4, 5'b00000}: ascii_o = 10'h048; // H
            {3'd4, 5'b00111}: ascii_o = 10'h04A; // J
            {3'd4, 5'b00100}: ascii_o = 10'h04C; // L
            {3'd4, 5'b00110}: ascii_o = 10'h050; // P
            {3'd4, 5'b01101}: ascii_o = 10'h051; // Q
            {3'd4, 5'b00001}: ascii_o = 10'h056; // V
            {3'd4, 5'b01001}: ascii_o = 10'h058; // X
            {3'd4, 5'b01011}: ascii_o = 10'h059; // Y
            {3'd4, 5'b01100}: ascii_o = 10'h05A; // Z
            {3'd5, 5'b11111}: ascii_o = 10'h030; // 0
            {3'd5, 5'b01111}: ascii_o = 10'h031;
            {3'd5, 5'b00111}: ascii_o = 10'h032;
            {3'd5, 5'b00011}: ascii_o = 10'h033;
            {3'd5, 5'b00001}: ascii_o = 10'h034;
            {3'd5, 5'b00000}: ascii_o = 10'h035;
            {3'd5, 5'b10000}: ascii_o = 10'h036;
            {3'd5, 5'b11000}: ascii_o = 10'h037;
            {3'd5, 5'b11100}: ascii_o = 10'h038;
            {3'd5, 5'b11110}: ascii_o = 10'h039;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_rx_decoder.sv
// On/off-keyed Morse receiver: times mark/space runs against UNIT_CYCLES,
// buffers dots/dashes and emits decoded ASCII, word spaces and error pulses.
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int MAX_SYMBOLS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       morse_i,
    output logic [9:0] character_o,
    output logic       char_valid_o,
    output logic       err_o
);

    // Thresholds are compared against cnt+1 so that they fire on the N-th sample.
    localparam logic [12:0]      CHAR_TH  = 13'(CHAR_GAP_UNITS * UNIT_CYCLES);
    localparam logic [12:0]      WORD_TH  = 13'(WORD_GAP_UNITS * UNIT_CYCLES);
    localparam logic [12:0]      STUCK_TH = 13'(STUCK_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES);
    localparam logic [2:0]       MAX_LEN  = 3'(MAX_SYMBOLS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       len_q, len_d;
    logic [4:0]       pat_q, pat_d;
    logic             ovf_q, ovf_d;
    logic [9:0]       char_q, char_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [12:0] cnt_plus;
    logic        sym_bit;
    logic        lut_valid;
    logic [9:0]  lut_ascii;

    assign cnt_plus = {2'b00, cnt_q} + 13'd1;
    assign sym_bit  = (cnt_q >= DASH_MIN) ? DASH : DOT;

    morse_lut u_lut (
        .len_i   (len_q),
        .pat_i   (pat_q),
        .valid_o (lut_valid),
        .ascii_o (lut_ascii)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            ovf_q   <= 1'b0;
            char_q  <= 10'h000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            ovf_q   <= ovf_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        pat_d   = pat_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (morse_i) begin
                    state_d = MARK;
                    cnt_d   = CNT_W'(1);
                end
            end
            MARK: begin
                if (morse_i) begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_plus == STUCK_TH) begin
                        state_d = STUCK;
                        len_d   = '0;
                        pat_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end else begin
                    if (len_q == MAX_LEN) begin
                        ovf_d = 1'b1;
                    end else begin
                        pat_d = {pat_q[3:0], sym_bit};
                        len_d = len_q + 3'd1;
                    end
                    state_d = SPACE;
                    cnt_d   = CNT_W'(1);
                end
            end
            SPACE: begin
                // A rising edge wins over the char-gap threshold in the same sample.
                if (morse_i) begin
                    state_d = MARK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_plus == CHAR_TH) begin
                        state_d = WORD_WAIT;
                        len_d   = '0;
                        pat_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            WORD_WAIT: begin
                if (morse_i) begin
                    state_d = MARK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_plus == WORD_TH) begin
                        state_d = IDLE;
                    end
                end
            end
            STUCK: begin
                cnt_d = sat_inc(cnt_q);
                if (!morse_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        char_d  = char_q;
        case (state_q)
            MARK: begin
                if (morse_i && (cnt_plus == STUCK_TH)) begin
                    err_d = 1'b1;
                end
            end
            SPACE: begin
                if (!morse_i && (cnt_plus == CHAR_TH)) begin
                    valid_d = 1'b1;
                    if (ovf_q || !lut_valid) begin
                        char_d = ASCII_QMARK;
                        err_d  = 1'b1;
                    end else begin
                        char_d = lut_ascii;
                    end
                end
            end
            WORD_WAIT: begin
                if (!morse_i && (cnt_plus == WORD_TH)) begin
                    valid_d = 1'b1;
                    char_d  = ASCII_SPACE;
                end
            end
            default: ;
        endcase
    end

    assign character_o  = char_q;
    assign char_valid_o = valid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Scoreboard bench for morse_rx_decoder: run-length stimulus, a run-level reference
// model that predicts each output pulse and its cycle, and a monitor that checks them.
module tb_morse_rx_decoder;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       morse_i;
    logic [9:0] character_o;
    logic       char_valid_o;
    logic       err_o;

    morse_rx_decoder #(.UNIT_CYCLES(U), .MAX_SYMBOLS(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .morse_i      (morse_i),
        .character_o  (character_o),
        .char_valid_o (char_valid_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         valid;
        bit         err;
        logic [9:0] ascii;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    string tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."
    };

    string buf_s      = "";
    bit    after_mark = 1'b0;

    function automatic logic [9:0] ascii_of(input int idx);
        return (idx < 26) ? 10'(65 + idx) : 10'(48 + idx - 26);
    endfunction

    task automatic push_ev(input bit v, input bit e, input logic [9:0] a, input int at);
        ev_t ev;
        ev.valid = v;
        ev.err   = e;
        ev.ascii = a;
        ev.at    = at;
        exp_q.push_back(ev);
    endtask

    // Drive one run of a constant level; the model predicts events from the run alone.
    task automatic send_run(input bit lvl, input int len);
        int   start;
        bit   found;
        logic [9:0] a;
        start = cyc + 1;
        if (lvl) begin
            if (len >= 5 * U) begin
                push_ev(1'b0, 1'b1, 10'h000, start + 5 * U - 1);
                buf_s      = "";
                after_mark = 1'b0;
            end else begin
                buf_s      = {buf_s, (len < 2 * U) ? "." : "-"};
                after_mark = 1'b1;
            end
        end else if (after_mark && len >= 2 * U) begin
            found = 1'b0;
            a     = 10'h03F;
            for (int i = 0; i < 36; i++) begin
                if (tab[i] == buf_s) begin
                    found = 1'b1;
                    a     = ascii_of(i);
                end
            end
            push_ev(1'b1, !found, a, start + 2 * U - 1);
            if (len >= 5 * U) push_ev(1'b1, 1'b0, 10'h020, start + 5 * U - 1);
            buf_s      = "";
            after_mark = 1'b0;
        end
        morse_i = lvl;
        repeat (len) @(negedge clk);
    endtask

    task automatic send_pattern(input string p, input int end_gap);
        for (int j = 0; j < p.len(); j++) begin
            if (j > 0) send_run(1'b0, 1 + $urandom_range(0, 2 * U - 2));
            if (p[j] == "-") send_run(1'b1, 2 * U + $urandom_range(0, 3 * U - 1));
            else             send_run(1'b1, 1 + $urandom_range(0, 2 * U - 2));
        end
        send_run(1'b0, end_gap);
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %03h, expected %03h", name, act, req);
        end else begin
            $display("[TB] check %s = %03h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (char_valid_o || err_o) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse@%0d: got valid=%0b err=%0b char=%03h, expected none",
                         cyc, char_valid_o, err_o, character_o);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (char_valid_o !== e.valid || err_o !== e.err || cyc != e.at ||
                    (e.valid && character_o !== e.ascii)) begin
                    fails++;
                    $display("FAIL pulse@%0d: got valid=%0b err=%0b char=%03h, expected valid=%0b err=%0b char=%03h at %0d",
                             cyc, char_valid_o, err_o, character_o, e.valid, e.err, e.ascii, e.at);
                end else begin
                    $display("[TB] pulse@%0d valid=%0b err=%0b char=%03h", cyc, char_valid_o, err_o, character_o);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        morse_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_char", character_o, 10'h000);
        check("reset_valid", {9'd0, char_valid_o}, 10'h000);
        check("reset_err", {9'd0, err_o}, 10'h000);
        reset = 1'b0;
        @(negedge clk);

        // E, then A with a word gap
        send_run(1'b1, 4);  send_run(1'b0, 8);
        send_run(1'b1, 4);  send_run(1'b0, 4);  send_run(1'b1, 12); send_run(1'b0, 20);
        // digit 5: five dots, digit 0: five dashes
        for (int k = 0; k < 5; k++) begin
            send_run(1'b1, 4); send_run(1'b0, (k == 4) ? 8 : 4);
        end
        for (int k = 0; k < 5; k++) begin
            send_run(1'b1, 12); send_run(1'b0, (k == 4) ? 8 : 4);
        end
        // overflow: six dots
        for (int k = 0; k < 6; k++) begin
            send_run(1'b1, 4); send_run(1'b0, (k == 5) ? 8 : 4);
        end
        // dot/dash boundary: 2U-1 is a dot, 2U is a dash -> 'A'
        send_run(1'b1, 2 * U - 1); send_run(1'b0, 2 * U - 1);
        send_run(1'b1, 2 * U);     send_run(1'b0, 2 * U);
        // stuck mark, then T
        send_run(1'b1, 30); send_run(1'b0, 8);
        send_run(1'b1, 12); send_run(1'b0, 8);
        // reset mid-character
        send_run(1'b1, 4); send_run(1'b0, 4); send_run(1'b1, 12);
        reset   = 1'b1;
        morse_i = 1'b0;
        buf_s      = "";
        after_mark = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        send_run(1'b0, 20);
        check("midreset_char", character_o, 10'h000);
        check("midreset_valid", {9'd0, char_valid_o}, 10'h000);
        check("midreset_err", {9'd0, err_o}, 10'h000);

        // randomized traffic: table characters, odd patterns, stuck marks
        for (int n = 0; n < 60; n++) begin
            int    r;
            int    gap;
            string p;
            r   = $urandom_range(0, 9);
            gap = ($urandom_range(0, 1) == 1) ? 2 * U + $urandom_range(0, 3 * U - 1)
                                              : 5 * U + $urandom_range(0, 10);
            if (r == 0) begin
                send_run(1'b1, 5 * U + $urandom_range(0, 8));
                send_run(1'b0, 1 + $urandom_range(0, 10));
            end else if (r == 1) begin
                p = "";
                for (int j = 0, m = $urandom_range(1, 6); j < m; j++)
                    p = {p, ($urandom_range(0, 1) == 1) ? "-" : "."};
                send_pattern(p, gap);
            end else begin
                send_pattern(tab[$urandom_range(0, 35)], gap);
            end
        end
        repeat (10) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
